bulls_cows_engine: RTL

BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

---
 rtl/bc_pkg.sv | 40 ++++
 rtl/bc_lfsr16.sv | 32 +++
 rtl/bulls_cows_engine.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// ============================================================================
// bc_pkg : shared types and constants for the bulls-and-cows engine
// Rev 1.0
// ============================================================================
`default_nettype none

package bc_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_ENTRY  = 3'd2,
      S_SCORE  = 3'd3,
      S_RESULT = 3'd4,
      S_WIN    = 3'd5,
      S_LOSE   = 3'd6
   } state_e;

   localparam logic [3:0]  c_bcd_blank = 4'hF;
   // Right-shift Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 0,2,3,5)
   localparam logic [15:0] c_lfsr_taps = 16'h002D;

   // True when the first n digits are all BCD (0..9) and mutually distinct
   function automatic logic digits_ok(input logic [31:0] v, input int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < n) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
               if (j < i && v[i*4 +: 4] == v[j*4 +: 4]) ok = 1'b0;
            end
         end
      end
      return ok;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bc_lfsr16.sv
// ============================================================================
// bc_lfsr16 : free-running 16-bit LFSR, reloaded with seed on reset
// Rev 1.0
// ============================================================================
`default_nettype none

module bc_lfsr16
   import bc_pkg::*;
(
   input  logic        clock,
   input  logic        resetButt,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {^(lfsr_q & c_lfsr_taps), lfsr_q[15:1]};
   end

   always_ff @(posedge clock) begin
      if (resetButt) lfsr_q <= seed;
      else           lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/bulls_cows_engine.sv
// ============================================================================
// bulls_cows_engine : secret generation, guess entry and A/B scoring FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module bulls_cows_engine
   import bc_pkg::*;
#(
   parameter int          NUM_DIGITS = 4,
   parameter int          MAX_TRIES  = 10,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                    clock,
   input  logic                    resetButt,
   input  logic                    startButt,
   input  logic                    secret_load,
   input  logic [NUM_DIGITS*4-1:0] secret_in,
   input  logic [3:0]              digit_in,
   input  logic                    digit_valid,
   input  logic                    clear,
   input  logic                    check,
   output logic [NUM_DIGITS*4-1:0] guess_out,
   output logic [3:0]              digit_count,
   output logic [3:0]              a_count,
   output logic [3:0]              b_count,
   output logic                    score_valid,
   output logic                    in_err,
   output logic [3:0]              tries,
   output logic                    win,
   output logic                    lose,
   output logic                    busy
);

   localparam int W = NUM_DIGITS * 4;

   logic [15:0] w_lfsr;
   logic        w_lfsr_unused;
   logic [3:0]  w_cand;

   bc_lfsr16 u_lfsr (
      .clock     (clock),
      .resetButt (resetButt),
      .seed      (LFSR_SEED),
      .q         (w_lfsr)
   );

   assign w_cand        = w_lfsr[3:0];
   assign w_lfsr_unused = ^w_lfsr[15:4];

   state_e      state_q, state_d;
   logic [W-1:0] secret_q, secret_d;
   logic [W-1:0] guess_q, guess_d;
   logic [3:0]  digit_count_q, digit_count_d;
   logic [3:0]  a_count_q, a_count_d;
   logic [3:0]  b_count_q, b_count_d;
   logic [3:0]  tries_q, tries_d;
   logic        score_valid_q, score_valid_d;
   logic        in_err_q, in_err_d;
   logic        win_q, win_d;
   logic        lose_q, lose_d;
   logic        busy_q, busy_d;
   logic [3:0]  gen_cnt_q, gen_cnt_d;
   logic [15:0] gen_used_q, gen_used_d;
   logic [3:0]  score_idx_q, score_idx_d;
   logic [3:0]  acc_a_q, acc_a_d;
   logic [3:0]  acc_b_q, acc_b_d;

   logic       w_dup;
   logic       w_hit_a;
   logic       w_hit_b;
   logic [3:0] w_gdig;

   always_comb begin
      state_d       = state_q;
      secret_d      = secret_q;
      guess_d       = guess_q;
      digit_count_d = digit_count_q;
      a_count_d     = a_count_q;
      b_count_d     = b_count_q;
      tries_d       = tries_q;
      score_valid_d = 1'b0;
      in_err_d      = 1'b0;
      gen_cnt_d     = gen_cnt_q;
      gen_used_d    = gen_used_q;
      score_idx_d   = score_idx_q;
      acc_a_d       = acc_a_q;
      acc_b_d       = acc_b_q;

      w_dup = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j < int'(digit_count_q) && guess_q[j*4 +: 4] == digit_in) w_dup = 1'b1;
      end

      // Secret digits are distinct, so a guess digit scores at most one hit
      w_gdig = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (4'(i) == score_idx_q) w_gdig = guess_q[i*4 +: 4];
      end
      w_hit_a = 1'b0;
      w_hit_b = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (secret_q[j*4 +: 4] == w_gdig) begin
            if (4'(j) == score_idx_q) w_hit_a = 1'b1;
            else                      w_hit_b = 1'b1;
         end
      end

      if (startButt || secret_load) begin
         guess_d       = {NUM_DIGITS{c_bcd_blank}};
         digit_count_d = 4'd0;
         tries_d       = 4'd0;
         a_count_d     = 4'd0;
         b_count_d     = 4'd0;
         gen_cnt_d     = 4'd0;
         gen_used_d    = 16'd0;
         if (startButt) begin
            secret_d = '0;
            state_d  = S_GEN;
         end else if (digits_ok(32'(secret_in), NUM_DIGITS)) begin
            secret_d = secret_in;
            state_d  = S_ENTRY;
         end else begin
            in_err_d = 1'b1;
            state_d  = S_IDLE;
         end
      end else begin
         case (state_q)
            S_GEN: begin
               if (w_cand <= 4'd9 && !gen_used_q[w_cand]) begin
                  secret_d           = {secret_q[W-5:0], w_cand};
                  gen_used_d[w_cand] = 1'b1;
                  gen_cnt_d          = gen_cnt_q + 4'd1;
                  if (gen_cnt_q == 4'(NUM_DIGITS - 1)) state_d = S_ENTRY;
               end
            end
            S_ENTRY: begin
               if (check) begin
                  if (digit_count_q == 4'(NUM_DIGITS)) begin
                     state_d     = S_SCORE;
                     score_idx_d = 4'd0;
                     acc_a_d     = 4'd0;
                     acc_b_d     = 4'd0;
                  end else begin
                     in_err_d = 1'b1;
                  end
               end else if (clear) begin
                  digit_count_d = 4'd0;
                  guess_d       = {NUM_DIGITS{c_bcd_blank}};
               end else if (digit_valid) begin
                  if (digit_in > 4'd9 || w_dup || digit_count_q == 4'(NUM_DIGITS)) begin
                     in_err_d = 1'b1;
                  end else begin
                     guess_d       = {guess_q[W-5:0], digit_in};
                     digit_count_d = digit_count_q + 4'd1;
                  end
               end
            end
            S_SCORE: begin
               acc_a_d     = acc_a_q + {3'd0, w_hit_a};
               acc_b_d     = acc_b_q + {3'd0, w_hit_b};
               score_idx_d = score_idx_q + 4'd1;
               if (score_idx_q == 4'(NUM_DIGITS - 1)) begin
                  state_d       = S_RESULT;
                  a_count_d     = acc_a_d;
                  b_count_d     = acc_b_d;
                  score_valid_d = 1'b1;
                  tries_d       = tries_q + 4'd1;
               end
            end
            S_RESULT: begin
               if (a_count_q == 4'(NUM_DIGITS)) begin
                  state_d = S_WIN;
               end else if (tries_q == 4'(MAX_TRIES)) begin
                  state_d = S_LOSE;
               end else begin
                  state_d       = S_ENTRY;
                  guess_d       = {NUM_DIGITS{c_bcd_blank}};
                  digit_count_d = 4'd0;
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == S_GEN) || (state_d == S_SCORE);
      win_d  = (state_d == S_WIN);
      lose_d = (state_d == S_LOSE);
   end

   always_ff @(posedge clock) begin
      if (resetButt) begin
         state_q       <= S_IDLE;
         secret_q      <= '0;
         guess_q       <= {NUM_DIGITS{c_bcd_blank}};
         digit_count_q <= 4'd0;
         a_count_q     <= 4'd0;
         b_count_q     <= 4'd0;
         tries_q       <= 4'd0;
         score_valid_q <= 1'b0;
         in_err_q      <= 1'b0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
         busy_q        <= 1'b0;
         gen_cnt_q     <= 4'd0;
         gen_used_q    <= 16'd0;
         score_idx_q   <= 4'd0;
         acc_a_q       <= 4'd0;
         acc_b_q       <= 4'd0;
      end else begin
         state_q       <= state_d;
         secret_q      <= secret_d;
         guess_q       <= guess_d;
         digit_count_q <= digit_count_d;
         a_count_q     <= a_count_d;
         b_count_q     <= b_count_d;
         tries_q       <= tries_d;
         score_valid_q <= score_valid_d;
         in_err_q      <= in_err_d;
         win_q         <= win_d;
         lose_q        <= lose_d;
         busy_q        <= busy_d;
         gen_cnt_q     <= gen_cnt_d;
         gen_used_q    <= gen_used_d;
         score_idx_q   <= score_idx_d;
         acc_a_q       <= acc_a_d;
         acc_b_q       <= acc_b_d;
      end
   end

   assign guess_out   = guess_q;
   assign digit_count = digit_count_q;
   assign a_count     = a_count_q;
   assign b_count     = b_count_q;
   assign tries       = tries_q;
   assign score_valid = score_valid_q;
   assign in_err      = in_err_q;
   assign win         = win_q;
   assign lose        = lose_q;
   assign busy        = busy_q;

endmodule

`default_nettype wire
